encounter_scheduler: RTL and testbench
======================================

Name: encounter_scheduler

Overview:
- Wild-encounter controller for the overworld.
- On each player step inside tall grass it rolls an encounter chance from a private 5-bit LFSR.
- On a hit it freezes the species generator (the 5-bit LFSR species picker, enable `en`, 3-bit `poke_num`), latches the species, and offers it to the battle FSM via a valid/ack handshake.
- After the battle ends it enforces a step-count cooldown before the next encounter.

Parameters:
- ENC_THRESH, 6 (6-bit, range 0..32): hit when enc_lfsr < ENC_THRESH. 0 means never; 32 means always.
- COOLDOWN_STEPS, 4 (8-bit): grass steps required after battle_done before rolls resume.
- NUM_SPECIES, 5: valid species ids are 0..NUM_SPECIES-1.

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- enc_enable  in  1  encounters allowed (menus/cutscenes drive 0)
- step_pulse  in  1  one-cycle pulse per completed tile move
- in_grass  in  1  player tile is grass, qualified with step_pulse
- rng_en  out  1  drives species generator `en`
- poke_num  in  3  species generator output
- enc_valid  out  1  encounter offered
- poke_id  out  3  latched species, stable while enc_valid
- enc_ack  in  1  battle FSM accepts the offer
- battle_done  in  1  one-cycle pulse at battle end
- busy  out  1  state != IDLE
- enc_count  out  8  encounters started, saturating at 255

Behaviour:
- Reset (async, Reset_n=0):
  - state=IDLE, enc_lfsr=5'h1F, cool_cnt=0, poke_id=0, enc_valid=0, enc_count=0.
  - rng_en=1, because rng_en = (state != LOCK).
- enc_lfsr runs freely every clock in all states: next = {lfsr[3:0], lfsr[4]^lfsr[2]}. Its period is 31 and it never reaches 0.
- IDLE:
  - step_pulse & in_grass & enc_enable → ROLL.
  - Any other step_pulse is ignored.
- ROLL (1 cycle):
  - Compare the zero-extended enc_lfsr against ENC_THRESH.
  - Hit → LOCK. Miss → IDLE.
  - enc_enable=0 during ROLL → IDLE (no hit).
- LOCK (1 cycle):
  - rng_en=0, so the species generator holds state and poke_num is stable.
  - At the exiting edge:
    - poke_id ← (poke_num < NUM_SPECIES) ? poke_num : 0.
    - enc_count += 1, saturating.
    - Next state: OFFER.
- OFFER:
  - enc_valid=1; poke_id is held.
  - enc_ack → BATTLE, with enc_valid=0 from the next cycle.
  - Ack latency is unbounded; enc_enable is ignored once in LOCK or later.
- BATTLE:
  - battle_done → COOLDOWN with cool_cnt ← COOLDOWN_STEPS.
  - If COOLDOWN_STEPS=0, go straight to IDLE.
- COOLDOWN:
  - Each step_pulse with in_grass decrements cool_cnt.
  - The decrement that reaches 0 → IDLE on the same edge. That step does not roll; the next grass step can.
  - Non-grass steps do not count.
- Ignored inputs:
  - enc_ack outside OFFER.
  - battle_done outside BATTLE.
  - A battle_done coincident with enc_ack in OFFER is ignored; only the ack is taken.
- rng_en is high in every state except LOCK. The species generator keeps stirring between encounters.
- poke_id holds its last value after the offer, until the next LOCK.
- Reset mid-operation (any state): immediate return to reset values. Any pending offer is dropped, with no ack required.
- All outputs come from registers or decode of the state register only; there is no input-to-output combinational path.

Decomposition:
- Package encounter_pkg:
  - enc_state_t enum {IDLE, ROLL, LOCK, OFFER, BATTLE, COOLDOWN}.
  - LFSR_SEED = 5'h1F.
  - SPECIES_W = 3.
- One sub-module, encounter_lfsr: the 5-bit free-running chance LFSR with async active-low reset to LFSR_SEED.
- The FSM, cooldown counter and species latch stay in encounter_scheduler.

Test Plan:
- ENC_THRESH=32, enc_enable=1, one grass step_pulse, bench generator returns poke_num=3:
  - ROLL, then LOCK with rng_en=0 for exactly 1 cycle.
  - enc_valid=1 with poke_id=3 on the 3rd cycle after the step.
  - enc_count=1.
- ENC_THRESH=0, 100 grass steps → enc_valid never asserts, enc_count=0, rng_en constantly 1.
- ENC_THRESH=32, bench drives poke_num=6 during LOCK → poke_id=0.
- Hold-off, with ENC_THRESH=32 and COOLDOWN_STEPS=4:
  - Hold enc_ack low for 20 cycles: enc_valid and poke_id stay stable.
  - Pulse enc_ack, then battle_done.
  - 4 grass steps produce no offer (one extra non-grass step also produces none).
  - The 5th grass step yields a new offer.
- Reset_n asserted while in OFFER → enc_valid=0, busy=0, enc_count=0 asynchronously. After release, enc_lfsr sequence restarts 1F,1E,1C,18,11.
- Simultaneous events:
  - battle_done together with enc_ack in OFFER → BATTLE. A later battle_done is required to leave.
  - enc_enable dropped during ROLL → no encounter.

Source files
------------

// File: rtl/encounter_pkg.sv
// Shared types and constants for the wild-encounter scheduler.
package encounter_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ROLL     = 3'd1,
    LOCK     = 3'd2,
    OFFER    = 3'd3,
    BATTLE   = 3'd4,
    COOLDOWN = 3'd5
  } enc_state_t;

  localparam logic [4:0] LFSR_SEED = 5'h1F;
  localparam int         SPECIES_W = 3;

endpackage

// File: rtl/encounter_lfsr.sv
// Free-running 5-bit maximal-length LFSR used for the encounter chance roll.
module encounter_lfsr
  import encounter_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset_n,
  output logic [4:0] lfsr
);

  logic [4:0] lfsr_r;

  // Shift every clock; the seed is non-zero so the all-zero lockup state is unreachable.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= {lfsr_r[3:0], lfsr_r[4] ^ lfsr_r[2]};
    end
  end

  assign lfsr = lfsr_r;

endmodule

// File: rtl/encounter_scheduler.sv
// Wild-encounter controller: rolls on grass steps, freezes and latches the species,
// offers it to the battle FSM and enforces a post-battle step cooldown.
module encounter_scheduler
  import encounter_pkg::*;
#(
  parameter logic [5:0] ENC_THRESH     = 6'd6,
  parameter logic [7:0] COOLDOWN_STEPS = 8'd4,
  parameter int         NUM_SPECIES    = 5
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 enc_enable,
  input  logic                 step_pulse,
  input  logic                 in_grass,
  output logic                 rng_en,
  input  logic [SPECIES_W-1:0] poke_num,
  output logic                 enc_valid,
  output logic [SPECIES_W-1:0] poke_id,
  input  logic                 enc_ack,
  input  logic                 battle_done,
  output logic                 busy,
  output logic [7:0]           enc_count
);

  localparam logic [SPECIES_W:0] NUM_SPECIES_V = (SPECIES_W + 1)'(NUM_SPECIES);

  enc_state_t           state_r;
  enc_state_t           state_nxt_s;
  logic [4:0]           enc_lfsr_s;
  logic [7:0]           cool_cnt_r;
  logic [SPECIES_W-1:0] poke_id_r;
  logic [7:0]           enc_count_r;
  logic                 grass_step_s;
  logic                 hit_s;

  encounter_lfsr u_lfsr (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .lfsr    (enc_lfsr_s)
  );

  assign grass_step_s = step_pulse & in_grass;
  assign hit_s        = ({1'b0, enc_lfsr_s} < ENC_THRESH);

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:     if (grass_step_s && enc_enable) state_nxt_s = ROLL;
                else                            state_nxt_s = IDLE;
      ROLL:     if (enc_enable && hit_s)        state_nxt_s = LOCK;
                else                            state_nxt_s = IDLE;
      LOCK:                                     state_nxt_s = OFFER;
      OFFER:    if (enc_ack)                    state_nxt_s = BATTLE;
                else                            state_nxt_s = OFFER;
      BATTLE: begin
        if (battle_done) begin
          if (COOLDOWN_STEPS == 8'd0) state_nxt_s = IDLE;
          else                        state_nxt_s = COOLDOWN;
        end else begin
          state_nxt_s = BATTLE;
        end
      end
      // The step that brings the counter to zero returns to IDLE without rolling.
      COOLDOWN: if (grass_step_s && (cool_cnt_r <= 8'd1)) state_nxt_s = IDLE;
                else                                      state_nxt_s = COOLDOWN;
      default:                                  state_nxt_s = IDLE;
    endcase
  end

  // Output decode from the state register only.
  always_comb begin
    rng_en    = (state_r != LOCK);
    enc_valid = (state_r == OFFER);
    busy      = (state_r != IDLE);
  end

  // Cooldown step counter.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cool_cnt_r <= 8'd0;
    end else if ((state_r == BATTLE) && battle_done) begin
      cool_cnt_r <= COOLDOWN_STEPS;
    end else if ((state_r == COOLDOWN) && grass_step_s && (cool_cnt_r != 8'd0)) begin
      cool_cnt_r <= cool_cnt_r - 8'd1;
    end else begin
      cool_cnt_r <= cool_cnt_r;
    end
  end

  // Species latch and saturating encounter counter, both updated as LOCK exits.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      poke_id_r   <= '0;
      enc_count_r <= 8'd0;
    end else if (state_r == LOCK) begin
      poke_id_r   <= ({1'b0, poke_num} < NUM_SPECIES_V) ? poke_num : '0;
      enc_count_r <= (enc_count_r == 8'hFF) ? enc_count_r : enc_count_r + 8'd1;
    end else begin
      poke_id_r   <= poke_id_r;
      enc_count_r <= enc_count_r;
    end
  end

  assign poke_id   = poke_id_r;
  assign enc_count = enc_count_r;

endmodule

// File: tb/tb_encounter_scheduler.sv
// Self-checking bench: three scheduler instances (thresholds 32/0/6) share stimulus
// and are compared every cycle against a behavioural model plus directed checks.
module tb_encounter_scheduler;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       enc_enable = 1'b0, step_pulse = 1'b0, in_grass = 1'b0;
  logic       enc_ack = 1'b0, battle_done = 1'b0;
  logic [2:0] poke_num = 3'd0;

  logic       rng_en_o[3], enc_valid_o[3], busy_o[3];
  logic [2:0] poke_id_o[3];
  logic [7:0] enc_count_o[3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  encounter_scheduler #(.ENC_THRESH(6'd32), .COOLDOWN_STEPS(8'd4), .NUM_SPECIES(5)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .enc_enable(enc_enable), .step_pulse(step_pulse),
    .in_grass(in_grass), .rng_en(rng_en_o[0]), .poke_num(poke_num), .enc_valid(enc_valid_o[0]),
    .poke_id(poke_id_o[0]), .enc_ack(enc_ack), .battle_done(battle_done), .busy(busy_o[0]),
    .enc_count(enc_count_o[0]));

  encounter_scheduler #(.ENC_THRESH(6'd0), .COOLDOWN_STEPS(8'd4), .NUM_SPECIES(5)) dut_never (
    .Clk(Clk), .Reset_n(Reset_n), .enc_enable(enc_enable), .step_pulse(step_pulse),
    .in_grass(in_grass), .rng_en(rng_en_o[1]), .poke_num(poke_num), .enc_valid(enc_valid_o[1]),
    .poke_id(poke_id_o[1]), .enc_ack(enc_ack), .battle_done(battle_done), .busy(busy_o[1]),
    .enc_count(enc_count_o[1]));

  encounter_scheduler #(.ENC_THRESH(6'd6), .COOLDOWN_STEPS(8'd0), .NUM_SPECIES(5)) dut_mid (
    .Clk(Clk), .Reset_n(Reset_n), .enc_enable(enc_enable), .step_pulse(step_pulse),
    .in_grass(in_grass), .rng_en(rng_en_o[2]), .poke_num(poke_num), .enc_valid(enc_valid_o[2]),
    .poke_id(poke_id_o[2]), .enc_ack(enc_ack), .battle_done(battle_done), .busy(busy_o[2]),
    .enc_count(enc_count_o[2]));

  // Reference model: phase per instance, shared chance sequence.
  localparam int P_IDLE = 0, P_ROLL = 1, P_LOCK = 2, P_OFFER = 3, P_BATTLE = 4, P_COOL = 5;
  int th[3] = '{32, 0, 6};
  int cd[3] = '{4, 4, 0};
  int ph[3], cool[3], cnt[3], poke[3];
  int m_lfsr;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      ph[k] = P_IDLE; cool[k] = 0; cnt[k] = 0; poke[k] = 0;
    end
    m_lfsr = 31;
  endfunction

  function automatic void model_edge();
    bit gstep;
    gstep = step_pulse && in_grass;
    for (int k = 0; k < 3; k++) begin
      case (ph[k])
        P_IDLE:   if (gstep && enc_enable) ph[k] = P_ROLL;
        P_ROLL:   ph[k] = (enc_enable && (m_lfsr < th[k])) ? P_LOCK : P_IDLE;
        P_LOCK: begin
          poke[k] = (poke_num < 5) ? int'(poke_num) : 0;
          if (cnt[k] < 255) cnt[k]++;
          ph[k] = P_OFFER;
        end
        P_OFFER:  if (enc_ack) ph[k] = P_BATTLE;
        P_BATTLE: if (battle_done) begin
          cool[k] = cd[k];
          ph[k] = (cd[k] == 0) ? P_IDLE : P_COOL;
        end
        P_COOL:   if (gstep) begin
          cool[k]--;
          if (cool[k] == 0) ph[k] = P_IDLE;
        end
        default:  ph[k] = P_IDLE;
      endcase
    end
    m_lfsr = ((m_lfsr * 2) % 32) + (((m_lfsr / 16) + (m_lfsr / 4)) % 2);
  endfunction

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("enc_valid[%0d]", k), 32'(enc_valid_o[k]), 32'(ph[k] == P_OFFER));
      check_eq($sformatf("busy[%0d]", k), 32'(busy_o[k]), 32'(ph[k] != P_IDLE));
      check_eq($sformatf("rng_en[%0d]", k), 32'(rng_en_o[k]), 32'(ph[k] != P_LOCK));
      check_eq($sformatf("poke_id[%0d]", k), 32'(poke_id_o[k]), 32'(poke[k]));
      check_eq($sformatf("enc_count[%0d]", k), 32'(enc_count_o[k]), 32'(cnt[k]));
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic grass_step(input logic grass);
    step_pulse = 1'b1; in_grass = grass;
    tick();
    step_pulse = 1'b0; in_grass = 1'b0;
    tick();
  endtask

  logic [4:0] exp_seq[4] = '{5'h1E, 5'h1C, 5'h18, 5'h11};

  initial begin
    model_reset();
    #12;
    check_eq("reset_valid", 32'(enc_valid_o[0]), 32'd0);
    check_eq("reset_rng_en", 32'(rng_en_o[0]), 32'd1);
    check_eq("reset_lfsr", 32'(dut.u_lfsr.lfsr), 32'h1F);
    Reset_n = 1'b1;
    enc_enable = 1'b1;
    repeat (3) tick();

    // First encounter: ROLL, one LOCK cycle, then offer of species 3.
    poke_num = 3'd3; step_pulse = 1'b1; in_grass = 1'b1;
    tick();
    check_eq("t1_roll_busy", 32'(busy_o[0]), 32'd1);
    step_pulse = 1'b0; in_grass = 1'b0;
    tick();
    check_eq("t1_lock_rng_en", 32'(rng_en_o[0]), 32'd0);
    tick();
    check_eq("t1_rng_en_back", 32'(rng_en_o[0]), 32'd1);
    check_eq("t1_valid", 32'(enc_valid_o[0]), 32'd1);
    check_eq("t1_poke_id", 32'(poke_id_o[0]), 32'd3);
    check_eq("t1_count", 32'(enc_count_o[0]), 32'd1);

    // Offer held across a long ack latency while the species input wanders.
    for (int i = 0; i < 20; i++) begin
      poke_num = 3'($urandom_range(0, 7));
      tick();
      check_eq("hold_valid", 32'(enc_valid_o[0]), 32'd1);
      check_eq("hold_poke", 32'(poke_id_o[0]), 32'd3);
    end
    enc_ack = 1'b1; tick(); enc_ack = 1'b0;
    check_eq("ack_valid_drop", 32'(enc_valid_o[0]), 32'd0);
    tick();
    battle_done = 1'b1; tick(); battle_done = 1'b0;

    grass_step(1'b1);
    grass_step(1'b1);
    grass_step(1'b0);
    grass_step(1'b1);
    check_eq("cool_3_busy", 32'(busy_o[0]), 32'd1);
    grass_step(1'b1);
    check_eq("cool_done_idle", 32'(busy_o[0]), 32'd0);
    check_eq("cool_no_offer", 32'(enc_count_o[0]), 32'd1);

    // Fifth grass step rolls; out-of-range species maps to 0.
    poke_num = 3'd6; step_pulse = 1'b1; in_grass = 1'b1;
    tick();
    step_pulse = 1'b0; in_grass = 1'b0;
    tick(); tick();
    check_eq("t5_valid", 32'(enc_valid_o[0]), 32'd1);
    check_eq("t5_poke_clamp", 32'(poke_id_o[0]), 32'd0);
    check_eq("t5_count", 32'(enc_count_o[0]), 32'd2);

    // battle_done together with ack: only the ack is taken.
    enc_ack = 1'b1; battle_done = 1'b1; tick();
    enc_ack = 1'b0; battle_done = 1'b0;
    repeat (3) tick();
    check_eq("coinc_still_battle", 32'(busy_o[0]), 32'd1);
    check_eq("coinc_no_valid", 32'(enc_valid_o[0]), 32'd0);
    battle_done = 1'b1; tick(); battle_done = 1'b0;
    repeat (4) grass_step(1'b1);
    check_eq("coinc_idle", 32'(busy_o[0]), 32'd0);

    // enc_enable dropped during ROLL cancels the encounter.
    step_pulse = 1'b1; in_grass = 1'b1; tick();
    step_pulse = 1'b0; in_grass = 1'b0; enc_enable = 1'b0; tick();
    enc_enable = 1'b1; tick();
    check_eq("en_drop_idle", 32'(busy_o[0]), 32'd0);
    check_eq("en_drop_count", 32'(enc_count_o[0]), 32'd2);

    // Reset while offering.
    poke_num = 3'd2;
    grass_step(1'b1); tick();
    check_eq("pre_rst_valid", 32'(enc_valid_o[0]), 32'd1);
    Reset_n = 1'b0;
    #1;
    model_reset();
    check_eq("rst_valid", 32'(enc_valid_o[0]), 32'd0);
    check_eq("rst_busy", 32'(busy_o[0]), 32'd0);
    check_eq("rst_count", 32'(enc_count_o[0]), 32'd0);
    #2 Reset_n = 1'b1;
    check_eq("rst_lfsr_seed", 32'(dut.u_lfsr.lfsr), 32'h1F);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq($sformatf("lfsr_seq%0d", i), 32'(dut.u_lfsr.lfsr), 32'(exp_seq[i]));
    end

    // Threshold 0 never hits.
    for (int i = 0; i < 100; i++) grass_step(1'b1);
    check_eq("never_count", 32'(enc_count_o[1]), 32'd0);
    check_eq("never_valid", 32'(enc_valid_o[1]), 32'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      step_pulse  = ($urandom_range(0, 2) == 0);
      in_grass    = ($urandom_range(0, 3) != 0);
      enc_enable  = ($urandom_range(0, 7) != 0);
      enc_ack     = ($urandom_range(0, 5) == 0);
      battle_done = ($urandom_range(0, 5) == 0);
      poke_num    = 3'($urandom_range(0, 7));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
